alu_seq: RTL

- Parametrised, handshaked successor to the single-cycle CPU ALU.
- Adds SRA, SLTU and the RV32M multiply/divide/remainder group.
- Basic ops complete in one registered cycle. Multiply and divide run iteratively over XLEN cycles.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle basic ops plus iterative RV32M multiply/divide.
// Accepts in IDLE, holds the registered result in DONE until out_ready.
module alu_seq #(
  parameter int unsigned XLEN  = 32,
  parameter bit          MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  localparam int unsigned     SW       = $clog2(XLEN);
  localparam logic [SW-1:0]   CNT_LAST = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT,
    OP_SRA, OP_SLTU, OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e            state_q;
  op_e               op_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              neg_q;
  logic [SW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q, quo_q, rem_q, dvsr_q;

  op_e               op_in;
  logic [XLEN-1:0]   a_mag, b_mag, imm_res, long_res, res_d;
  logic              sgn_op, ovf, is_md, is_mul, go_long, zero_d;
  logic [2*XLEN-1:0] mul_sum, mul_fin;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   div_rem, div_quo;

  always_comb begin
    op_in   = op_e'(alu_op);
    a_mag   = a[XLEN-1] ? -a : a;
    b_mag   = b[XLEN-1] ? -b : b;
    sgn_op  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    is_mul  = op_in inside {OP_MUL, OP_MULH};
    ovf     = (a == INT_MIN) && (b == '1) && (op_in inside {OP_DIV, OP_REM});
    is_md   = MD_EN && alu_op[3] && (alu_op[2] || alu_op[1]);
    // Divide-by-zero and signed overflow resolve immediately instead of iterating.
    go_long = is_md && !ovf && (is_mul || (b != '0));

    imm_res = '0;
    case (op_in)
      OP_ADD:  imm_res = a + b;
      OP_SUB:  imm_res = a - b;
      OP_AND:  imm_res = a & b;
      OP_OR:   imm_res = a | b;
      OP_XOR:  imm_res = a ^ b;
      OP_SLL:  imm_res = a << b[SW-1:0];
      OP_SRL:  imm_res = a >> b[SW-1:0];
      OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRA:  imm_res = $signed(a) >>> b[SW-1:0];
      OP_SLTU: imm_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_DIV, OP_DIVU: if (MD_EN) imm_res = (b == '0) ? '1 : (ovf ? a : '0);
      OP_REM, OP_REMU: if (MD_EN) imm_res = (b == '0) ? a : '0;
      default: imm_res = '0;
    endcase

    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_fin  = neg_q ? -mul_sum : mul_sum;
    div_sh   = {rem_q, quo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, dvsr_q};
    div_rem  = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    div_quo  = {quo_q[XLEN-2:0], ~div_diff[XLEN]};

    long_res = '0;
    case (op_q)
      OP_MUL:          long_res = mul_fin[XLEN-1:0];
      OP_MULH:         long_res = mul_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: long_res = neg_q ? -div_quo : div_quo;
      OP_REM, OP_REMU: long_res = neg_q ? -div_rem : div_rem;
      default:         long_res = '0;
    endcase

    res_d  = (state_q == S_IDLE) ? imm_res : long_res;
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q     <= op_in;
          cnt_q    <= '0;
          acc_q    <= '0;
          rem_q    <= '0;
          // Signed ops iterate on magnitudes; the sign is reapplied on the final step.
          neg_q    <= (op_in == OP_REM) ? a[XLEN-1] : (sgn_op && (a[XLEN-1] ^ b[XLEN-1]));
          mcand_q  <= {{XLEN{1'b0}}, (sgn_op ? a_mag : a)};
          mplier_q <= sgn_op ? b_mag : b;
          quo_q    <= sgn_op ? a_mag : a;
          dvsr_q   <= sgn_op ? b_mag : b;
          if (go_long) begin
            state_q <= is_mul ? S_MUL : S_DIV;
          end else begin
            result_q <= res_d;
            zero_q   <= zero_d;
            state_q  <= S_DONE;
          end
        end
        S_MUL: begin
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q <= res_d;
            zero_q   <= zero_d;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          rem_q <= div_rem;
          quo_q <= div_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q <= res_d;
            zero_q   <= zero_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
endmodule
